// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search sequencer.
// Holds the FSM state encoding, S-memory select codes and default key geometry.
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_S,
    ST_INIT_R,
    ST_KSA_S,
    ST_KSA_R,
    ST_PRGA_S,
    ST_PRGA_R,
    ST_NEXT_KEY,
    ST_FOUND,
    ST_EXHAUSTED,
    ST_HALTED,
    ST_ERROR
  } search_state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_INIT = 2'b01;
  localparam logic [1:0] SEL_KSA  = 2'b10;
  localparam logic [1:0] SEL_PRGA = 2'b11;

  localparam int                    DEF_KEY_W    = 24;
  localparam logic [DEF_KEY_W-1:0]  DEF_KEY_LAST = 24'h3FFFFF;

  // The S-memory belongs to whichever engine is being started or is running.
  function automatic logic [1:0] sel_for_state(input search_state_t s);
    case (s)
      ST_INIT_S, ST_INIT_R: return SEL_INIT;
      ST_KSA_S,  ST_KSA_R:  return SEL_KSA;
      ST_PRGA_S, ST_PRGA_R: return SEL_PRGA;
      default:              return SEL_NONE;
    endcase
  endfunction

  function automatic logic is_busy_state(input search_state_t s);
    case (s)
      ST_IDLE, ST_FOUND, ST_EXHAUSTED, ST_HALTED, ST_ERROR: return 1'b0;
      default:                                             return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/rc4_key_stepper.sv
// Key counter for one search core: strided key advance, end-of-range detect
// and a saturating count of rejected keys.
module rc4_key_stepper
  import rc4_pkg::*;
#(
  parameter int               KEY_W      = DEF_KEY_W,
  parameter logic [KEY_W-1:0] KEY_START  = '0,
  parameter logic [KEY_W-1:0] KEY_STRIDE = KEY_W'(1),
  parameter logic [KEY_W-1:0] KEY_LAST   = KEY_W'(DEF_KEY_LAST),
  parameter int               CNT_W      = 24
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             step,
  input  logic             hold,
  output logic [KEY_W-1:0] key,
  output logic             last,
  output logic [CNT_W-1:0] tried
);

  logic [KEY_W:0] nxt_wide;

  // One extra bit catches a stride that wraps past the top of the key space.
  assign nxt_wide = {1'b0, key} + {1'b0, KEY_STRIDE};
  assign last     = (nxt_wide > {1'b0, KEY_LAST});

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      key   <= KEY_START;
      tried <= '0;
    end else if (step) begin
      tried <= (tried == '1) ? tried : tried + CNT_W'(1);
      if (!hold && !last)
        key <= nxt_wide[KEY_W-1:0];
    end
  end

endmodule

// File: rtl/rc4_search_core.sv
// Key-search sequencer for one RC4 decryption core: walks a strided key range and
// drives the S-init, KSA and PRGA engines in turn, with watchdog and terminal states.
module rc4_search_core
  import rc4_pkg::*;
#(
  parameter int               KEY_W       = DEF_KEY_W,
  parameter logic [KEY_W-1:0] KEY_START   = '0,
  parameter logic [KEY_W-1:0] KEY_STRIDE  = KEY_W'(1),
  parameter logic [KEY_W-1:0] KEY_LAST    = KEY_W'(DEF_KEY_LAST),
  parameter int               TIMEOUT_CYC = 4096,
  parameter int               CNT_W       = 24
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             stop_in,
  input  logic             init_done,
  input  logic             ksa_done,
  input  logic             prga_ok,
  input  logic             prga_fail,
  output logic             init_start,
  output logic             ksa_start,
  output logic             prga_start,
  output logic [1:0]       mem_sel,
  output logic [KEY_W-1:0] current_key,
  output logic             found,
  output logic [KEY_W-1:0] found_key,
  output logic             exhausted,
  output logic             halted,
  output logic             error,
  output logic             busy,
  output logic [CNT_W-1:0] keys_tried
);

  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYC);

  search_state_t state, ns;
  logic [31:0]   wd;
  logic          wd_expired;
  logic          key_last;
  logic          step;

  assign step       = (state == ST_NEXT_KEY);
  assign wd_expired = (TIMEOUT_CYC != 0) && ((wd + 32'd1) >= TO_LIM);

  rc4_key_stepper #(
    .KEY_W     (KEY_W),
    .KEY_START (KEY_START),
    .KEY_STRIDE(KEY_STRIDE),
    .KEY_LAST  (KEY_LAST),
    .CNT_W     (CNT_W)
  ) u_stepper (
    .CLOCK_50(CLOCK_50),
    .reset_n (reset_n),
    .step    (step),
    .hold    (stop_in),
    .key     (current_key),
    .last    (key_last),
    .tried   (keys_tried)
  );

  always_comb begin
    ns = state;
    case (state)
      ST_IDLE:     if (enable) ns = ST_INIT_S;
      ST_INIT_S:   ns = ST_INIT_R;
      ST_INIT_R:   if (init_done) ns = ST_KSA_S;
                   else if (wd_expired) ns = ST_ERROR;
      ST_KSA_S:    ns = ST_KSA_R;
      ST_KSA_R:    if (ksa_done) ns = ST_PRGA_S;
                   else if (wd_expired) ns = ST_ERROR;
      ST_PRGA_S:   ns = ST_PRGA_R;
      // A match beats a simultaneous reject so a valid plaintext is never dropped.
      ST_PRGA_R:   if (prga_ok) ns = ST_FOUND;
                   else if (prga_fail) ns = ST_NEXT_KEY;
                   else if (wd_expired) ns = ST_ERROR;
      ST_NEXT_KEY: if (stop_in) ns = ST_HALTED;
                   else if (key_last) ns = ST_EXHAUSTED;
                   else ns = ST_INIT_S;
      default:     ns = state;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      init_start <= 1'b0;
      ksa_start  <= 1'b0;
      prga_start <= 1'b0;
      mem_sel    <= SEL_NONE;
      found      <= 1'b0;
      found_key  <= '0;
      exhausted  <= 1'b0;
      halted     <= 1'b0;
      error      <= 1'b0;
      busy       <= 1'b0;
      wd         <= '0;
    end else begin
      state      <= ns;
      init_start <= (ns == ST_INIT_S);
      ksa_start  <= (ns == ST_KSA_S);
      prga_start <= (ns == ST_PRGA_S);
      mem_sel    <= sel_for_state(ns);
      busy       <= is_busy_state(ns);
      found      <= found     | (ns == ST_FOUND);
      exhausted  <= exhausted | (ns == ST_EXHAUSTED);
      halted     <= halted    | (ns == ST_HALTED);
      error      <= error     | (ns == ST_ERROR);
      if (ns == ST_FOUND && state != ST_FOUND)
        found_key <= current_key;
      // Watchdog measures cycles since the phase start pulse.
      if (ns == ST_INIT_S || ns == ST_KSA_S || ns == ST_PRGA_S)
        wd <= '0;
      else if (TIMEOUT_CYC != 0 && sel_for_state(state) != SEL_NONE)
        wd <= wd + 32'd1;
    end
  end

endmodule

// File: tb/tb_rc4_search_core.sv
// Directed bench for rc4_search_core: three configurations covering match,
// range exhaustion, stop handling, watchdog and mid-phase reset.
module tb_rc4_search_core;

  logic        CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic        reset_n [3];
  logic        enable [3];
  logic        stop_in [3];
  logic        init_done [3];
  logic        ksa_done [3];
  logic        prga_ok [3];
  logic        prga_fail [3];
  logic        init_start [3];
  logic        ksa_start [3];
  logic        prga_start [3];
  logic [1:0]  mem_sel [3];
  logic [23:0] current_key [3];
  logic        found [3];
  logic [23:0] found_key [3];
  logic        exhausted [3];
  logic        halted [3];
  logic        error [3];
  logic        busy [3];
  logic [23:0] keys_tried [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Instance 0: start 5 stride 4, watchdog 16. Instance 1: top of range. Instance 2: start 7.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    rc4_search_core #(
      .KEY_W      (24),
      .KEY_START  (g == 0 ? 24'd5 : (g == 1 ? 24'h3FFFFE : 24'd7)),
      .KEY_STRIDE (g == 0 ? 24'd4 : 24'd1),
      .KEY_LAST   (24'h3FFFFF),
      .TIMEOUT_CYC(g == 0 ? 16 : 4096),
      .CNT_W      (24)
    ) u_dut (
      .CLOCK_50   (CLOCK_50),
      .reset_n    (reset_n[g]),
      .enable     (enable[g]),
      .stop_in    (stop_in[g]),
      .init_done  (init_done[g]),
      .ksa_done   (ksa_done[g]),
      .prga_ok    (prga_ok[g]),
      .prga_fail  (prga_fail[g]),
      .init_start (init_start[g]),
      .ksa_start  (ksa_start[g]),
      .prga_start (prga_start[g]),
      .mem_sel    (mem_sel[g]),
      .current_key(current_key[g]),
      .found      (found[g]),
      .found_key  (found_key[g]),
      .exhausted  (exhausted[g]),
      .halted     (halted[g]),
      .error      (error[g]),
      .busy       (busy[g]),
      .keys_tried (keys_tried[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic pulse_reset(input int k);
    reset_n[k] = 1'b0;
    tick();
    reset_n[k] = 1'b1;
  endtask

  // Entered in the INIT_S cycle; returns in the cycle after PRGA_R (FOUND or NEXT_KEY).
  // res: 0 reject, 1 match, 2 both pulses together.
  task automatic run_key(input int k, input logic [23:0] key, input int res,
                         input bit stop, input string tag);
    check({tag, ".init_start"}, init_start[k], 1);
    check({tag, ".key"}, current_key[k], key);
    check({tag, ".sel_init"}, mem_sel[k], 2'b01);
    tick();
    init_done[k] = 1'b1;
    tick();
    init_done[k] = 1'b0;
    check({tag, ".ksa_start"}, ksa_start[k], 1);
    check({tag, ".sel_ksa"}, mem_sel[k], 2'b10);
    tick();
    ksa_done[k] = 1'b1;
    tick();
    ksa_done[k] = 1'b0;
    check({tag, ".prga_start"}, prga_start[k], 1);
    check({tag, ".sel_prga"}, mem_sel[k], 2'b11);
    tick();
    if (stop) begin
      stop_in[k] = 1'b1;
      tick();
      check({tag, ".stop_no_abort"}, mem_sel[k], 2'b11);
    end
    prga_ok[k]   = (res != 0);
    prga_fail[k] = (res != 1);
    tick();
    prga_ok[k]   = 1'b0;
    prga_fail[k] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      reset_n[i] = 1'b0; enable[i] = 1'b0; stop_in[i] = 1'b0;
      init_done[i] = 1'b0; ksa_done[i] = 1'b0; prga_ok[i] = 1'b0; prga_fail[i] = 1'b0;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) reset_n[i] = 1'b1;
    tick();

    // Reset state
    check("rst.key_a", current_key[0], 24'd5);
    check("rst.key_b", current_key[1], 24'h3FFFFE);
    check("rst.key_c", current_key[2], 24'd7);
    check("rst.busy", busy[0], 0);
    check("rst.sel", mem_sel[0], 0);
    check("rst.init_start", init_start[0], 0);
    check("rst.tried", keys_tried[0], 0);
    check("rst.found", found[0], 0);

    // Strided search: 5 and 9 rejected, 13 matches
    enable[0] = 1'b1;
    tick();
    run_key(0, 24'd5, 0, 0, "k5");
    check("nk1.busy", busy[0], 1);
    check("nk1.sel", mem_sel[0], 0);
    check("nk1.tried", keys_tried[0], 0);
    tick();
    check("nk1.tried_after", keys_tried[0], 1);
    run_key(0, 24'd9, 0, 0, "k9");
    tick();
    run_key(0, 24'd13, 1, 0, "k13");
    check("fnd.found", found[0], 1);
    check("fnd.found_key", found_key[0], 24'd13);
    check("fnd.tried", keys_tried[0], 2);
    check("fnd.busy", busy[0], 0);
    check("fnd.sel", mem_sel[0], 0);
    enable[0] = 1'b0;
    tick();
    check("fnd.sticky", found[0], 1);

    // Match and reject in the same cycle: match wins
    pulse_reset(0);
    check("both.rst_found", found[0], 0);
    enable[0] = 1'b1;
    tick();
    run_key(0, 24'd5, 2, 0, "both");
    check("both.found", found[0], 1);
    check("both.found_key", found_key[0], 24'd5);
    check("both.tried", keys_tried[0], 0);

    // Stray init_done in KSA_R, then watchdog expiry with ksa_done withheld
    pulse_reset(0);
    tick();
    check("wd.init_start", init_start[0], 1);
    tick();
    init_done[0] = 1'b1;
    tick();
    init_done[0] = 1'b0;
    check("wd.ksa_start", ksa_start[0], 1);
    tick();
    init_done[0] = 1'b1;
    tick();
    init_done[0] = 1'b0;
    check("stray.ksa_start", ksa_start[0], 0);
    check("stray.prga_start", prga_start[0], 0);
    check("stray.sel", mem_sel[0], 2'b10);
    check("stray.busy", busy[0], 1);
    repeat (13) tick();
    check("wd.err_before", error[0], 0);
    check("wd.sel_before", mem_sel[0], 2'b10);
    tick();
    check("wd.error", error[0], 1);
    check("wd.sel", mem_sel[0], 0);
    check("wd.busy", busy[0], 0);
    tick();
    check("wd.sticky", error[0], 1);

    // Reset in the middle of KSA_R
    pulse_reset(0);
    tick();
    tick();
    init_done[0] = 1'b1;
    tick();
    init_done[0] = 1'b0;
    tick();
    check("mid.in_ksa", mem_sel[0], 2'b10);
    enable[0] = 1'b0;
    pulse_reset(0);
    check("mid.sel", mem_sel[0], 0);
    check("mid.busy", busy[0], 0);
    check("mid.ksa_start", ksa_start[0], 0);
    check("mid.key", current_key[0], 24'd5);
    check("mid.error", error[0], 0);
    tick();
    check("mid.idle", init_start[0], 0);
    enable[0] = 1'b1;
    tick();
    check("mid.restart", init_start[0], 1);
    check("mid.restart_sel", mem_sel[0], 2'b01);

    // Top of key range: 3FFFFE and 3FFFFF both rejected
    enable[1] = 1'b1;
    tick();
    run_key(1, 24'h3FFFFE, 0, 0, "kfe");
    tick();
    run_key(1, 24'h3FFFFF, 0, 0, "kff");
    check("exh.pre", exhausted[1], 0);
    tick();
    check("exh.exhausted", exhausted[1], 1);
    check("exh.tried", keys_tried[1], 2);
    check("exh.key", current_key[1], 24'h3FFFFF);
    check("exh.busy", busy[1], 0);
    check("exh.init_start", init_start[1], 0);
    check("exh.found", found[1], 0);

    // stop_in during PRGA_R, then reject: halted on key 7
    enable[2] = 1'b1;
    tick();
    run_key(2, 24'd7, 0, 1, "h7");
    check("halt.pre", halted[2], 0);
    tick();
    check("halt.halted", halted[2], 1);
    check("halt.key", current_key[2], 24'd7);
    check("halt.tried", keys_tried[2], 1);
    check("halt.busy", busy[2], 0);
    check("halt.init_start", init_start[2], 0);
    stop_in[2] = 1'b0;

    // stop_in during PRGA_R, then match: found wins
    pulse_reset(2);
    tick();
    run_key(2, 24'd7, 1, 1, "s7");
    check("stopok.found", found[2], 1);
    check("stopok.found_key", found_key[2], 24'd7);
    check("stopok.halted", halted[2], 0);
    tick();
    check("stopok.still_halted0", halted[2], 0);
    stop_in[2] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
